// File: rtl/texture_mapper_mult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : texture_mapper_mult_arbiter (+ texture_mapper_legup_mult)
//  Purpose  : Round-robin arbiter sharing one pipelined multiplier between
//             NUM_REQ requesters. Each issued multiply carries a requester
//             tag down a tag pipeline that runs in lock-step with the
//             multiplier. Results come back on one shared, tagged bus. The
//             whole pipeline freezes while the consumer back-pressures.
//  Ports    : clock, aclr            - clock, asynchronous active-high reset
//             req_valid/req_ready    - per-requester handshake (ready one-hot)
//             req_dataa/req_datab    - packed operands, requester i at
//                                      [i*WIDTH +: WIDTH]
//             res_valid/res_ready    - result handshake
//             res_id/res_data        - result tag and product
//             stat_issue_cnt/
//             stat_stall_cnt         - saturating counters, present only
//                                      when TEXTURE_MAPPER_MULT_ARB_STATS_EN
//                                      is defined
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Pipelined multiplier: PIPELINE register stages, all gated by clken.
// The product is formed on operands extended to WIDTHP bits (sign- or
// zero-extended according to REPRESENTATION), keeping the low WIDTHP bits.
// ----------------------------------------------------------------------------
module texture_mapper_legup_mult #(
  parameter int    WIDTHA         = 32,
  parameter int    WIDTHB         = 32,
  parameter int    WIDTHP         = 64,
  parameter int    PIPELINE       = 3,
  parameter string REPRESENTATION = "UNSIGNED"
) (
  input  logic              clock,
  input  logic              aclr,
  input  logic              clken,
  input  logic [WIDTHA-1:0] dataa,
  input  logic [WIDTHB-1:0] datab,
  output logic [WIDTHP-1:0] result
);

  logic [WIDTHP-1:0] ext_a;
  logic [WIDTHP-1:0] ext_b;
  logic [WIDTHP-1:0] prod;
  logic [WIDTHP-1:0] pipe_q [PIPELINE];

  if (REPRESENTATION == "SIGNED") begin : g_signed
    logic signed [WIDTHA-1:0] sa;
    logic signed [WIDTHB-1:0] sb;
    assign sa    = dataa;
    assign sb    = datab;
    assign ext_a = WIDTHP'(sa);
    assign ext_b = WIDTHP'(sb);
  end else begin : g_unsigned
    assign ext_a = WIDTHP'(dataa);
    assign ext_b = WIDTHP'(datab);
  end

  // Low WIDTHP bits of a two's-complement product do not depend on signedness
  // once the operands are properly extended.
  assign prod = ext_a * ext_b;

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      for (int i = 0; i < PIPELINE; i++) pipe_q[i] <= '0;
    end else if (clken) begin
      pipe_q[0] <= prod;
      for (int i = 1; i < PIPELINE; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign result = pipe_q[PIPELINE-1];

endmodule

// ----------------------------------------------------------------------------
// Arbiter top
// ----------------------------------------------------------------------------
module texture_mapper_mult_arbiter #(
  parameter int    NUM_REQ        = 4,
  parameter int    WIDTHA         = 32,
  parameter int    WIDTHB         = 32,
  parameter int    WIDTHP         = 64,
  parameter int    PIPELINE       = 3,
  parameter string REPRESENTATION = "UNSIGNED",
  parameter int    ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clock,
  input  logic                      aclr,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*WIDTHA-1:0] req_dataa,
  input  logic [NUM_REQ*WIDTHB-1:0] req_datab,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [ID_W-1:0]           res_id,
  output logic [WIDTHP-1:0]         res_data
`ifdef TEXTURE_MAPPER_MULT_ARB_STATS_EN
  ,
  output logic [31:0]               stat_issue_cnt,
  output logic [31:0]               stat_stall_cnt
`endif
);

  localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

  logic              stall;
  logic              adv;
  logic              grant_vld;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W:0]     scan;
  logic [WIDTHA-1:0] sel_a;
  logic [WIDTHB-1:0] sel_b;

  logic [ID_W-1:0]     ptr_q;
  logic [ID_W-1:0]     ptr_d;
  logic [PIPELINE-1:0] tag_vld_q;
  logic [ID_W-1:0]     tag_id_q [PIPELINE];

  // Only a valid result that the consumer refuses can freeze the pipeline;
  // a bubble in the last stage never stalls.
  assign stall = res_valid & ~res_ready;
  assign adv   = ~stall;

  // Rotating priority scan starting at ptr_q. scan carries one extra bit so
  // ptr_q + k never overflows before the modulo wrap.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    scan      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (scan >= NUM_REQ_W) scan = scan - NUM_REQ_W;
      if (adv && !grant_vld && req_valid[scan[ID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_id  = scan[ID_W-1:0];
      end
    end
  end

  assign req_ready = grant_vld ? (NUM_REQ'(1) << grant_id) : '0;

  // Operand mux; zero when idle so the multiplier input is deterministic.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_vld && grant_id == ID_W'(i)) begin
        sel_a = req_dataa[i*WIDTHA +: WIDTHA];
        sel_b = req_datab[i*WIDTHB +: WIDTHB];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_vld) ptr_d = (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

  // Tag pipeline moves in lock-step with the multiplier (same adv enable).
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      tag_vld_q <= '0;
      for (int i = 0; i < PIPELINE; i++) tag_id_q[i] <= '0;
    end else if (adv) begin
      tag_vld_q[0] <= grant_vld;
      tag_id_q[0]  <= grant_id;
      for (int i = 1; i < PIPELINE; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

  assign res_valid = tag_vld_q[PIPELINE-1];
  assign res_id    = tag_id_q[PIPELINE-1];

  texture_mapper_legup_mult #(
    .WIDTHA         (WIDTHA),
    .WIDTHB         (WIDTHB),
    .WIDTHP         (WIDTHP),
    .PIPELINE       (PIPELINE),
    .REPRESENTATION (REPRESENTATION)
  ) u_mult (
    .clock  (clock),
    .aclr   (aclr),
    .clken  (adv),
    .dataa  (sel_a),
    .datab  (sel_b),
    .result (res_data)
  );

`ifdef TEXTURE_MAPPER_MULT_ARB_STATS_EN
  logic [31:0] issue_cnt_q;
  logic [31:0] stall_cnt_q;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (grant_vld && issue_cnt_q != '1) issue_cnt_q <= issue_cnt_q + 32'd1;
      if (stall && stall_cnt_q != '1)     stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stat_issue_cnt = issue_cnt_q;
  assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: doc/texture_mapper_mult_arbiter.md
# texture_mapper_mult_arbiter

Round-robin arbiter that shares one pipelined texture-mapper multiplier between `NUM_REQ` requesters. It sits between the texture-mapper datapath stages and a single `texture_mapper_legup_mult` instance, which it owns internally. It issues at most one multiply per cycle and tags each operation with its requester index. Results return on a shared bus with that tag. A full-pipeline stall is applied when the consumer back-pressures.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..16
- `WIDTHA`, 32: operand A width
- `WIDTHB`, 32: operand B width
- `WIDTHP`, 64: product width
- `PIPELINE`, 3: multiplier latency in cycles, ≥1
- `REPRESENTATION`, "UNSIGNED": "UNSIGNED" or "SIGNED", passed to the multiplier
- `ID_W`, max(1, clog2(NUM_REQ)): tag width

Ports:
- `clock`  in  1  sole clock, rising edge
- `aclr`  in  1  asynchronous active-high reset
- `req_valid`  in  NUM_REQ  per-requester operation valid
- `req_ready`  out  NUM_REQ  per-requester grant/accept, one-hot or zero
- `req_dataa`  in  NUM_REQ*WIDTHA  packed operand A; requester i occupies bits [i*WIDTHA +: WIDTHA]
- `req_datab`  in  NUM_REQ*WIDTHB  packed operand B, same packing
- `res_valid`  out  1  result valid
- `res_ready`  in  1  consumer accepts result
- `res_id`  out  ID_W  requester index of the result
- `res_data`  out  WIDTHP  product
- `stat_issue_cnt`  out  32  issued operations (only with the macro)
- `stat_stall_cnt`  out  32  stall cycles (only with the macro)

## Operation
- **Stall and advance.**
  - `stall = res_valid & ~res_ready`.
  - `adv = ~stall`; `adv` drives the multiplier `clken`.
- **Grant.**
  - Grant is combinational. When `adv` is high, scan `req_valid` starting at pointer `ptr` and wrapping modulo NUM_REQ. The first set bit wins.
  - `req_ready` is one-hot on the winner and zero otherwise.
  - While stalled, `req_ready` is all zeros.
  - A handshake (`req_valid[i] & req_ready[i]`) muxes requester i's operands into the multiplier.
- **Pointer.**
  - Reset value is 0.
  - On a handshake with requester i, `ptr <= (i+1) mod NUM_REQ`.
  - With no handshake, `ptr` holds.
- **Tag pipeline.**
  - A `PIPELINE`-deep shift register carries {valid, id} alongside the multiplier.
  - It shifts only when `adv` is high.
  - Stage 0 loads {handshake, winner id}. An idle cycle inserts a bubble (valid=0).
- **Result outputs.**
  - `res_valid` and `res_id` come from the last tag stage; `res_data` comes from the multiplier `result`.
  - A stalled result holds `res_data`, `res_id` and `res_valid` stable until accepted.
- **Operand width.** No operand truncation. The product width rule is that of the multiplier, per `REPRESENTATION`.
- **Reset.**
  - All tag valids clear, `ptr`=0, `res_valid`=0, `res_id`=0, `res_data`=0 (multiplier `aclr`), counters=0.
  - Operations in flight at reset are dropped; no result is produced for them.
- **Interface rule.** A requester must hold its operands stable while `req_valid` is high and `req_ready` is low.

## Timing
- Latency is exactly `PIPELINE` cycles from the handshake edge to `res_valid`, plus one cycle per stall cycle in between.
- Throughput is one operation per cycle when `res_ready` is held high.
- Back-to-back operations from different requesters return in issue order; there is no reordering.
- **Simultaneous events.**
  - If `res_valid & res_ready` and a new request arrive in the same cycle, the pipeline advances and the grant proceeds.
  - If the last stage is a bubble (`res_valid`=0), there is no stall, regardless of `res_ready`.
- **Fairness bound.** A continuously valid requester is granted within NUM_REQ non-stalled cycles.
- `aclr` takes effect asynchronously. The first grant is possible on the first rising edge after deassertion.

## Configuration
- Macro: `TEXTURE_MAPPER_MULT_ARB_STATS_EN`.
- **Defined:** the two 32-bit counters exist.
  - `stat_issue_cnt` increments on every handshake.
  - `stat_stall_cnt` increments on every cycle with `stall`=1.
  - Both saturate at 0xFFFF_FFFF; they do not wrap.
  - Both clear on `aclr`.
- **Undefined:** the counter ports and logic are absent. All other behaviour is identical.

## Test plan
- **Single requester.** Req 2 valid with A=7, B=6 (NUM_REQ=4, PIPELINE=3), `res_ready`=1 → `req_ready`=4'b0100 for one cycle; 3 cycles later `res_valid`=1, `res_id`=2, `res_data`=42.
- **Round robin.** All 4 requesters held valid, each with A=i+1, B=10 → grants in order 0,1,2,3,0,…; results 10,20,30,40 with ids 0..3 on consecutive cycles.
- **Back-pressure.** Two ops in flight, `res_ready`=0 for 5 cycles → `res_data` and `res_id` are held, `req_ready`=0 throughout; after release, both results are delivered in order with none lost or duplicated.
- **Signed.** REPRESENTATION="SIGNED", WIDTHA=WIDTHB=16, WIDTHP=32, A=-3 (0xFFFD), B=5 → `res_data`=0xFFFFFFF1.
- **Reset mid-flight.** Issue 3 ops, assert `aclr` 1 cycle after the third handshake → `res_valid` stays 0 for the next 5 cycles, `ptr` restarts at 0 (next grant with all valid goes to req 0).
- **Stats (macro defined).** 6 handshakes and 4 stall cycles → `stat_issue_cnt`=6, `stat_stall_cnt`=4; after `aclr`, both read 0.
